// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants and small decode helpers
// used by the VGA sync generator and its consumers.
package vga_timing_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL  = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL  = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  // Level driven on hsync/vsync while the pulse is asserted.
  localparam logic VGA_SYNC_ACTIVE = 1'b0;

  localparam int VGA_COORD_W = 10;
  typedef logic [VGA_COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_decode_t;

  function automatic logic in_window(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Clock-enable divider: o_tick is a registered one-clock pulse every DIV
// clocks, high on the clock where the phase count sits at DIV-1.
module pixel_tick_div #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [CW-1:0] w_cnt_nxt;

  assign w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;

  // The pulse is decoded from the next count so it lines up with the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == LAST);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters and registered
// sync/video decode that switch on the same edge as the coordinates.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = 4,
  parameter int   H_DISPLAY   = VGA_H_DISPLAY,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_DISPLAY   = VGA_V_DISPLAY,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  logic         w_tick;
  logic         w_h_wrap;
  logic         w_v_wrap;
  coord_t       w_x_nxt;
  coord_t       w_y_nxt;
  sync_decode_t w_dec;

  coord_t r_x;
  coord_t r_y;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_video_on;
  logic   r_frame_start;

  pixel_tick_div #(.DIV(CLK_DIV)) u_tick_div (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .o_tick  (w_tick)
  );

  assign w_h_wrap = (r_x == H_LAST);
  assign w_v_wrap = (r_y == V_LAST);

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_tick) begin
      w_x_nxt = w_h_wrap ? '0 : r_x + 1'b1;
      if (w_h_wrap) begin
        w_y_nxt = w_v_wrap ? '0 : r_y + 1'b1;
      end
    end
  end

  // Decoding the next-state coordinates keeps sync/video aligned with pixel_x/y.
  always_comb begin
    w_dec          = '0;
    w_dec.hsync    = in_window(w_x_nxt, HS_START, HS_END);
    w_dec.vsync    = in_window(w_y_nxt, VS_START, VS_END);
    w_dec.video_on = (int'(w_x_nxt) < H_DISPLAY) && (int'(w_y_nxt) < V_DISPLAY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hsync       <= w_dec.hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync       <= w_dec.vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_video_on    <= w_dec.video_on;
      r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
    end
  end

  assign p_tick      = w_tick;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign video_on    = r_video_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default /4 timing, /1 timing and a tiny
// /2 timing instance for whole-frame checks, plus a per-clock reference model.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst_n_v;
  logic [2:0]      pt, vo, hs, vs, fs;
  logic [2:0][9:0] px, py;

  int n_checks = 0;
  int n_pass   = 0;

  vga_sync_gen #(.CLK_DIV(4)) u_dut (
    .clk(clk), .reset_n(rst_n_v[0]), .p_tick(pt[0]), .pixel_x(px[0]), .pixel_y(py[0]),
    .video_on(vo[0]), .hsync(hs[0]), .vsync(vs[0]), .frame_start(fs[0])
  );

  vga_sync_gen #(.CLK_DIV(1)) u_dut_div1 (
    .clk(clk), .reset_n(rst_n_v[1]), .p_tick(pt[1]), .pixel_x(px[1]), .pixel_y(py[1]),
    .video_on(vo[1]), .hsync(hs[1]), .vsync(vs[1]), .frame_start(fs[1])
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_dut_small (
    .clk(clk), .reset_n(rst_n_v[2]), .p_tick(pt[2]), .pixel_x(px[2]), .pixel_y(py[2]),
    .video_on(vo[2]), .hsync(hs[2]), .vsync(vs[2]), .frame_start(fs[2])
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // ---------------- reference model, one slot per instance ----------------
  typedef struct {
    int div; int hd; int hf; int hs; int hb; int vd; int vf; int vs; int vb;
  } cfg_t;

  function automatic cfg_t cfg_of(input int i);
    cfg_t c;
    case (i)
      0:       c = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
      1:       c = '{1, 640, 16, 96, 48, 480, 10, 2, 33};
      default: c = '{2, 8, 2, 3, 2, 6, 1, 2, 1};
    endcase
    return c;
  endfunction

  int m_cnt[3];
  int m_x[3];
  int m_y[3];
  bit m_tick[3];
  bit m_fs[3];
  bit m_valid[3];
  int align_err[3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      cfg_t c;
      int   ht;
      int   vt;
      c  = cfg_of(i);
      ht = c.hd + c.hf + c.hs + c.hb;
      vt = c.vd + c.vf + c.vs + c.vb;
      if (!rst_n_v[i]) begin
        m_cnt[i] = 0; m_tick[i] = 0; m_x[i] = 0; m_y[i] = 0; m_fs[i] = 0; m_valid[i] = 0;
      end else begin
        m_fs[i] = m_tick[i] && (m_x[i] == ht - 1) && (m_y[i] == vt - 1);
        if (m_tick[i]) begin
          if (m_x[i] == ht - 1) begin
            m_x[i] = 0;
            m_y[i] = (m_y[i] == vt - 1) ? 0 : m_y[i] + 1;
          end else begin
            m_x[i] = m_x[i] + 1;
          end
        end
        m_cnt[i]   = (m_cnt[i] == c.div - 1) ? 0 : m_cnt[i] + 1;
        m_tick[i]  = (m_cnt[i] == c.div - 1);
        m_valid[i] = 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      cfg_t c;
      int   e_x, e_y, h0, v0;
      bit   e_pt, e_fs, e_vo, e_hs, e_vs;
      c = cfg_of(i);
      if (!rst_n_v[i]) begin
        e_x = 0; e_y = 0; e_pt = 0; e_fs = 0; e_vo = 0; e_hs = 1; e_vs = 1;
      end else begin
        h0   = c.hd + c.hf;
        v0   = c.vd + c.vf;
        e_x  = m_x[i];
        e_y  = m_y[i];
        e_pt = m_tick[i];
        e_fs = m_fs[i];
        e_vo = m_valid[i] && (m_x[i] < c.hd) && (m_y[i] < c.vd);
        e_hs = !(m_valid[i] && (m_x[i] >= h0) && (m_x[i] < h0 + c.hs));
        e_vs = !(m_valid[i] && (m_y[i] >= v0) && (m_y[i] < v0 + c.vs));
      end
      if (int'(px[i]) != e_x || int'(py[i]) != e_y || pt[i] !== e_pt || fs[i] !== e_fs ||
          vo[i] !== e_vo || hs[i] !== e_hs || vs[i] !== e_vs)
        align_err[i]++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] tick_mask;
    int edge_n, start_n, n, hs_low, hs_min, hs_max, vo_fall_x, vo_at_799, tick_zero;
    int fs_cnt, vs_low, vo_high;
    bit prev_vo;

    rst_n_v = '0;
    repeat (3) @(negedge clk);
    chk("rst_p_tick", pt[0], 0);
    chk("rst_pixel_x", px[0], 0);
    chk("rst_pixel_y", py[0], 0);
    chk("rst_hsync", hs[0], 1);
    chk("rst_vsync", vs[0], 1);
    chk("rst_video_on", vo[0], 0);
    chk("rst_frame_start", fs[0], 0);

    // /4 instance: first eight clocks after release
    rst_n_v[0] = 1'b1;
    tick_mask  = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tick_mask[k-1] = pt[0];
      if (k == 1) chk("video_on_first_edge", vo[0], 1);
      if (k == 3) chk("px_after_edge3", px[0], 0);
      if (k == 4) chk("px_after_edge4", px[0], 1);
      if (k == 8) chk("px_after_edge8", px[0], 2);
    end
    chk("tick_pattern", tick_mask, 8'h44);

    // one full line
    edge_n = 8; hs_low = 0; hs_min = 1023; hs_max = 0; vo_fall_x = -1; vo_at_799 = -1;
    prev_vo = 1'b1;
    while (py[0] == 0 && edge_n < 4000) begin
      @(negedge clk);
      edge_n++;
      if (py[0] == 0) begin
        if (!hs[0]) begin
          hs_low++;
          if (px[0] < hs_min) hs_min = px[0];
          if (px[0] > hs_max) hs_max = px[0];
        end
        if (prev_vo && !vo[0] && vo_fall_x < 0) vo_fall_x = px[0];
        if (px[0] == 799) vo_at_799 = vo[0];
        prev_vo = vo[0];
      end
    end
    chk("line_edges", edge_n, 3200);
    chk("line_wrap_x", px[0], 0);
    chk("line_wrap_y", py[0], 1);
    chk("video_on_rise_at_wrap", vo[0], 1);
    chk("video_on_at_x799", vo_at_799, 0);
    chk("video_on_fall_x", vo_fall_x, 640);
    chk("hsync_low_clks", hs_low, 384);
    chk("hsync_first_x", hs_min, 656);
    chk("hsync_last_x", hs_max, 751);

    // asynchronous reset mid-line while hsync is asserted
    n = 0;
    while (px[0] != 700 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_x700", px[0], 700);
    chk("hsync_at_x700", hs[0], 0);
    #1 rst_n_v[0] = 1'b0;
    #1;
    chk("async_rst_x", px[0], 0);
    chk("async_rst_y", py[0], 0);
    chk("async_rst_hsync", hs[0], 1);
    chk("async_rst_video_on", vo[0], 0);
    chk("async_rst_p_tick", pt[0], 0);
    @(negedge clk);
    rst_n_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("restart_tick_phase", pt[0], 1);
    chk("restart_x_before_tick", px[0], 0);
    @(negedge clk);
    chk("restart_x_after_tick", px[0], 1);

    // /1 instance: tick every clock, 800-clock line
    rst_n_v[1] = 1'b1;
    edge_n = 0; tick_zero = 0;
    @(negedge clk);
    edge_n = 1;
    chk("div1_tick_first_edge", pt[1], 1);
    while (py[1] == 0 && edge_n < 2000) begin
      @(negedge clk);
      edge_n++;
      if (!pt[1]) tick_zero++;
    end
    chk("div1_first_wrap_edges", edge_n, 801);
    start_n = edge_n;
    while (py[1] == 1 && edge_n < 3000) begin
      @(negedge clk);
      edge_n++;
      if (!pt[1]) tick_zero++;
    end
    chk("div1_line_clks", edge_n - start_n, 800);
    chk("div1_tick_gaps", tick_zero, 0);

    // tiny timing, /2: whole frames (15x10 pixels, hsync x 10..12, vsync y 7..8)
    rst_n_v[2] = 1'b1;
    edge_n = 0;
    while (!fs[2] && edge_n < 1000) begin
      @(negedge clk);
      edge_n++;
    end
    chk("small_first_frame_start_edge", edge_n, 300);
    chk("small_fs_x", px[2], 0);
    chk("small_fs_y", py[2], 0);
    fs_cnt = 0; vs_low = 0; hs_low = 0; vo_high = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (fs[2]) fs_cnt++;
      if (!vs[2]) vs_low++;
      if (!hs[2]) hs_low++;
      if (vo[2]) vo_high++;
    end
    chk("small_frame_start_count", fs_cnt, 1);
    chk("small_frame_start_at_end", fs[2], 1);
    chk("small_vsync_low_clks", vs_low, 60);
    chk("small_hsync_low_clks", hs_low, 60);
    chk("small_video_on_clks", vo_high, 96);
    @(negedge clk);
    chk("small_frame_start_width", fs[2], 0);

    chk("align_dut_div4", align_err[0], 0);
    chk("align_dut_div1", align_err[1], 0);
    chk("align_dut_small", align_err[2], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing generator for the 640x480@60 Hz VGA path. It divides the 100 MHz system clock into a one-cycle pixel-tick enable. It runs horizontal and vertical counters on that tick and emits hsync, vsync, video_on and the current pixel coordinates. Its pixel_x, pixel_y and video_on outputs feed the character/data generator that forms font-ROM addresses. Its hsync and vsync drive the VGA connector directly.

Parameters:
CLK_DIV, 4, system clocks per pixel tick (100 MHz -> 25 MHz); legal 1..16
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous active-low reset
p_tick  output  1  one-clk pixel enable, high every CLK_DIV clocks
pixel_x  output  10  horizontal count, 0..H_TOTAL-1
pixel_y  output  10  vertical count, 0..V_TOTAL-1
video_on  output  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
hsync  output  1  horizontal sync, level SYNC_ACTIVE while asserted
vsync  output  1  vertical sync, level SYNC_ACTIVE while asserted
frame_start  output  1  one-clk pulse on the tick where counters wrap to (0,0)

Behaviour:
- Totals: H_TOTAL = sum of the four H params = 800. V_TOTAL = sum of the four V params = 525.
- Reset (asynchronous, reset_n=0): the following values hold while reset_n is low.
  - div count = 0, p_tick = 0.
  - pixel_x = 0, pixel_y = 0.
  - hsync = vsync = ~SYNC_ACTIVE (deasserted).
  - video_on = 0, frame_start = 0.
- Divider: counts 0..CLK_DIV-1 and wraps. p_tick is registered and is high for exactly the clk where the count equals CLK_DIV-1. With CLK_DIV=1, p_tick is high every clk after reset release.
- Counters advance only on clk edges where p_tick=1.
  - pixel_x increments and wraps from H_TOTAL-1 to 0.
  - pixel_y increments only on the tick where pixel_x wraps, and wraps from V_TOTAL-1 to 0.
- Decoded outputs (hsync, vsync, video_on) are registered from the next-state counter values. They therefore change on the same clk edge as pixel_x/pixel_y: zero skew, zero added latency relative to the coordinates.
  - hsync asserted iff H_DISPLAY+H_FRONT <= pixel_x <= H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - vsync asserted iff V_DISPLAY+V_FRONT <= pixel_y <= V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
  - video_on = (pixel_x<640) && (pixel_y<480).
  - First clk edge after reset release: the decode registers load the decode of (0,0), so video_on goes to 1 and syncs stay deasserted.
- frame_start: registered. It is 1 for the single clk following the tick that moves (799,524) to (0,0), and 0 otherwise. It is not asserted on reset release.
- Reset mid-frame: everything returns immediately to reset values. Timing restarts from (0,0) with the divider phase at 0.
- Outputs are glitch-free because every output is driven directly by a flop.
- Sync and porch widths must satisfy H_SYNC>=1 and V_SYNC>=1. Counter width is fixed at 10 bits, so H_TOTAL and V_TOTAL must be <=1024.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640x480 timing constants (display, porches, sync widths);
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - the sync polarity constant.
- One natural sub-module, pixel_tick_div: parameterised clock-enable divider that produces p_tick. It is reused elsewhere for slower UI enables.

Test Plan:
- Reset, then release and run 8 clks with CLK_DIV=4 -> p_tick high at clk 4 and clk 8 after release, never two consecutive cycles; pixel_x steps 0->1->2.
- Run one full line of 3200 clks -> hsync low exactly for pixel_x 656..751 (96 ticks, 384 clks); video_on falls when pixel_x goes 639->640 and rises at 799->0; pixel_y goes 0->1 on the same edge pixel_x wraps.
- Run one full frame of 800*525*4 = 1,680,000 clks -> vsync low for exactly 2 lines (pixel_y 490..491, 6400 clks); frame_start pulses exactly once, one clk wide, at the (799,524)->(0,0) wrap.
- Check alignment on every clk edge -> video_on, hsync and vsync always equal the decode of the current pixel_x/pixel_y (scoreboard model, no off-by-one).
- Assert reset_n=0 asynchronously mid-line at pixel_x=700 with hsync asserted -> hsync deasserts, pixel_x/pixel_y go to 0 and video_on goes to 0 without waiting for a clk edge.
- Re-elaborate with CLK_DIV=1 -> p_tick is constantly 1 after release, and one line takes exactly 800 clks.
